// File: rtl/uart_loader_pkg.sv
// ---------------------------------------------------------------------------
// uart_loader_pkg
//   Shared constants and types for the UART packet loader.
//   SYNC_BYTE  : first byte of every packet
//   CMD_WRITE  : the only command the loader understands
//   state_t    : packet-parser states, one per packet field
// ---------------------------------------------------------------------------
package uart_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [7:0] CMD_WRITE = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR_H = 3'd2,
    ST_ADDR_L = 3'd3,
    ST_LEN    = 3'd4,
    ST_DATA   = 3'd5,
    ST_CHK    = 3'd6
  } state_t;

endpackage

// File: rtl/uart_loader.sv
// ---------------------------------------------------------------------------
// uart_loader
//   Receives SYNC, CMD, ADDR_H, ADDR_L, LEN, data..., CHK over a UART byte
//   stream and writes the data bytes into memory at consecutive addresses.
//   Reports end of packet with a one-cycle done pulse; error flags a bad
//   command, a bad checksum or an inter-byte timeout.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   rx_valid   in   byte-available level from the UART receiver
//   rx_byte    in   received byte, stable while rx_valid is high
//   mem_we     out  one-cycle write strobe
//   mem_addr   out  write address (valid with mem_we)
//   mem_wdata  out  write data (valid with mem_we)
//   loading    out  high while a packet is in progress
//   done       out  one-cycle end-of-packet pulse
//   error      out  packet failed, only meaningful with done
// ---------------------------------------------------------------------------
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 120000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        loading,
  output logic        done,
  output logic        error
);

  localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CLKS);

  state_t            state_q, state_d;
  logic              rx_prev_q, rx_prev_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        sum_q, sum_d;
  logic              mem_we_q, mem_we_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              loading_q, loading_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              byte_acc;
  logic [GAP_W-1:0]  gap_inc;
  logic              timeout;
  logic [7:0]        chk_total;

  // A byte is the rising edge of rx_valid, so a level held for several
  // cycles still counts once. Timeout fires on the cycle the gap counter
  // would reach the limit, and any byte arriving that same cycle wins.
  always_comb begin
    byte_acc  = rx_valid && !rx_prev_q;
    rx_prev_d = rx_valid;
    gap_inc   = gap_q + 1'b1;
    timeout   = (state_q != ST_IDLE) && !byte_acc && (gap_inc == GAP_LIMIT);
    chk_total = sum_q + rx_byte;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each accepted byte advances one field; DATA repeats
  // until the remaining count hits its last byte.
  always_comb begin
    state_d = state_q;
    if (byte_acc) begin
      case (state_q)
        ST_IDLE:   if (rx_byte == SYNC_BYTE) state_d = ST_CMD;
        ST_CMD:    state_d = (rx_byte == CMD_WRITE) ? ST_ADDR_H : ST_IDLE;
        ST_ADDR_H: state_d = ST_ADDR_L;
        ST_ADDR_L: state_d = ST_LEN;
        ST_LEN:    state_d = ST_DATA;
        ST_DATA:   if (cnt_q == 9'd1) state_d = ST_CHK;
        ST_CHK:    state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
    end
  end

  // Datapath and output logic. Everything leaving the block comes from a
  // flop, so each strobe lands one cycle after the byte that caused it.
  // loading follows the next state so it drops together with done.
  always_comb begin
    gap_d       = '0;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    loading_d   = (state_d != ST_IDLE);

    if (state_q != ST_IDLE && !byte_acc && !timeout) begin
      gap_d = gap_inc;
    end

    if (byte_acc) begin
      case (state_q)
        ST_IDLE: sum_d = 8'h00;
        ST_CMD: begin
          sum_d = rx_byte;
          if (rx_byte != CMD_WRITE) begin
            done_d  = 1'b1;
            error_d = 1'b1;
          end
        end
        ST_ADDR_H: begin
          addr_d[15:8] = rx_byte;
          sum_d        = sum_q + rx_byte;
        end
        ST_ADDR_L: begin
          addr_d[7:0] = rx_byte;
          sum_d       = sum_q + rx_byte;
        end
        ST_LEN: begin
          // LEN of zero encodes a full 256-byte block
          cnt_d = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
          sum_d = sum_q + rx_byte;
        end
        ST_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = rx_byte;
          addr_d      = addr_q + 16'd1;
          cnt_d       = cnt_q - 9'd1;
          sum_d       = sum_q + rx_byte;
        end
        ST_CHK: begin
          done_d  = 1'b1;
          error_d = (chk_total != 8'h00);
        end
        default: ;
      endcase
    end else if (timeout) begin
      done_d  = 1'b1;
      error_d = 1'b1;
    end
  end

  // Datapath and output registers. The edge history resets high so a
  // receiver level already asserted at reset release is not taken as a byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_prev_q   <= 1'b1;
      gap_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      sum_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      loading_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      rx_prev_q   <= rx_prev_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      sum_q       <= sum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      loading_q   <= loading_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign loading   = loading_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_uart_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_loader
//   Scoreboard bench for uart_loader with TIMEOUT_CLKS = 100. Expected write
//   and done events are derived from whole packets and queued; a monitor
//   pops them whenever the loader strobes mem_we or done.
// ---------------------------------------------------------------------------
module tb_uart_loader;

  typedef logic [7:0] bytes_t[$];

  typedef struct {
    bit          is_done;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        loading;
  logic        done;
  logic        error;

  int tests;
  int failed;
  int cyc;
  int last_acc_cyc;
  int done_cyc;
  exp_t sb[$];

  uart_loader #(.TIMEOUT_CLKS(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .loading   (loading),
    .done      (done),
    .error     (error)
  );

  // 100 MHz clock and a free-running cycle index for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write or done strobe.
  always @(negedge clk) begin
    exp_t e;
    if (done) done_cyc = cyc;
    if (!done && error) begin
      tests++;
      failed++;
      $display("[TB] FAIL stray_error: error=1 while done=0 at cycle %0d", cyc);
    end
    if (mem_we || done) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_event: we=%0b done=%0b addr=%h data=%h, expected nothing",
                 mem_we, done, mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if (e.is_done) begin
          checkOutput("done_strobe", 32'(done), 32'd1);
          checkOutput("done_error", 32'(error), 32'(e.err));
          checkOutput("done_no_we", 32'(mem_we), 32'd0);
        end else begin
          checkOutput("write_strobe", 32'(mem_we), 32'd1);
          checkOutput("write_addr", 32'(mem_addr), 32'(e.addr));
          checkOutput("write_data", 32'(mem_wdata), 32'(e.data));
        end
      end
    end
  end

  // Reference model: expected events for one packet starting at SYNC.
  task automatic model_packet(input bytes_t pk);
    exp_t e;
    int n;
    int s;
    int base;
    if (pk[1] != 8'h01) begin
      e = '{is_done: 1'b1, addr: 16'h0, data: 8'h0, err: 1'b1};
      sb.push_back(e);
      return;
    end
    base = {pk[2], pk[3]};
    n = (pk[4] == 8'h00) ? 256 : int'(pk[4]);
    s = 0;
    for (int i = 1; i <= 4 + n; i++) s += int'(pk[i]);
    for (int i = 0; i < n; i++) begin
      e = '{is_done: 1'b0, addr: 16'((base + i) % 65536), data: pk[5 + i], err: 1'b0};
      sb.push_back(e);
    end
    e = '{is_done: 1'b1, addr: 16'h0, data: 8'h0, err: ((s + int'(pk[5 + n])) % 256) != 0};
    sb.push_back(e);
  endtask

  function automatic bytes_t make_packet(input logic [7:0] cmd, input logic [15:0] addr,
                                         input logic [7:0] len, input bit bad);
    bytes_t pk;
    int n;
    int s;
    logic [7:0] chk;
    pk = '{8'h55, cmd, addr[15:8], addr[7:0], len};
    n = (len == 8'h00) ? 256 : int'(len);
    for (int i = 0; i < n; i++) pk.push_back(8'($urandom));
    s = 0;
    for (int i = 1; i < pk.size(); i++) s += int'(pk[i]);
    chk = 8'((256 - (s % 256)) % 256);
    if (bad) chk = chk ^ 8'($urandom_range(255, 1));
    pk.push_back(chk);
    return pk;
  endfunction

  // One byte as a clean edge, level held for 'hold' cycles.
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    last_acc_cyc = cyc;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  // Queue the expected events, then send the packet. A rejected command
  // ends the packet after CMD. stall_at delays that byte to land exactly
  // on the timeout cycle.
  task automatic applyStimulus(input bytes_t pk, input int hold_min, input int hold_max,
                               input int stall_at);
    int n_send;
    model_packet(pk);
    n_send = (pk[1] == 8'h01) ? pk.size() : 2;
    for (int i = 0; i < n_send; i++) begin
      if (i == stall_at) repeat (98) @(posedge clk);
      send_byte(pk[i], $urandom_range(hold_max, hold_min));
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL %s_drain: %0d events still pending, expected 0", name, sb.size());
      sb.delete();
    end
    checkOutput({name, "_loading_after"}, 32'(loading), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bytes_t pk;
    tests    = 0;
    failed   = 0;
    done_cyc = -1;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset_loading", 32'(loading), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    reset = 1'b0;

    // Good packet, three writes at C000.
    pk = '{8'h55, 8'h01, 8'hC0, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'hD6};
    applyStimulus(pk, 1, 1, -1);
    wait_drain("good_c000", 50);

    // Same packet with a bad checksum: writes kept, error reported.
    pk = '{8'h55, 8'h01, 8'hC0, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    applyStimulus(pk, 1, 1, -1);
    wait_drain("bad_chk", 50);

    // Address wrap FFFF -> 0000.
    pk = '{8'h55, 8'h01, 8'hFF, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h9A};
    applyStimulus(pk, 1, 1, -1);
    wait_drain("wrap", 50);

    // Junk in IDLE then an unknown command.
    send_byte(8'h12, 1);
    checkOutput("junk_loading", 32'(loading), 32'd0);
    pk = '{8'h55, 8'h07};
    applyStimulus(pk, 1, 1, -1);
    wait_drain("bad_cmd", 50);

    // Silence after C0: timeout exactly 100 cycles after its acceptance.
    model_packet('{8'h55, 8'h07});
    send_byte(8'h55, 1);
    send_byte(8'h01, 1);
    send_byte(8'hC0, 1);
    done_cyc = -1;
    wait_drain("timeout", 200);
    checkOutput("timeout_latency", 32'(done_cyc - last_acc_cyc), 32'd100);
    pk = '{8'h55, 8'h01, 8'hC0, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'hD6};
    applyStimulus(pk, 1, 1, -1);
    wait_drain("after_timeout", 50);

    // A byte landing on the expiry cycle keeps the packet alive.
    applyStimulus(pk, 1, 1, 4);
    wait_drain("byte_wins", 50);

    // Level held three cycles per byte: one write per byte.
    applyStimulus(pk, 3, 3, -1);
    wait_drain("held_level", 50);

    // Reset during the second data byte, with rx_valid high across release.
    model_packet('{8'h55, 8'h01, 8'hC0, 8'h00, 8'h01, 8'h11, 8'hFF});
    void'(sb.pop_back());
    send_byte(8'h55, 1);
    send_byte(8'h01, 1);
    send_byte(8'hC0, 1);
    send_byte(8'h00, 1);
    send_byte(8'h03, 1);
    send_byte(8'h11, 1);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_byte  = 8'h22;
    reset    = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("midreset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("midreset_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("midreset_loading", 32'(loading), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_error", 32'(error), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held_at_release_loading", 32'(loading), 32'd0);
    rx_valid = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    wait_drain("midreset", 10);
    applyStimulus(pk, 1, 2, -1);
    wait_drain("after_reset", 50);

    // Randomized packets with junk prefixes, bad commands and checksums.
    for (int k = 0; k < 14; k++) begin
      logic [7:0]  cmd;
      logic [15:0] addr;
      logic [7:0]  len;
      logic [7:0]  junk;
      int njunk;
      njunk = $urandom_range(2, 0);
      for (int j = 0; j < njunk; j++) begin
        junk = 8'($urandom);
        if (junk == 8'h55) junk = 8'h54;
        send_byte(junk, $urandom_range(3, 1));
      end
      cmd = 8'h01;
      if ($urandom_range(5, 0) == 0) cmd = 8'($urandom_range(255, 2));
      addr = (k == 3) ? 16'hFFFE : 16'($urandom);
      len  = (k == 5) ? 8'h00 : 8'($urandom_range(6, 1));
      pk = make_packet(cmd, addr, len, $urandom_range(2, 0) == 0);
      applyStimulus(pk, 1, 3, -1);
      wait_drain("random", 50);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
